// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - round-robin arbiter sharing one 1-2-3 symbol pattern counter
//
// Purpose:
//   NREQ requesters compete for a single 2-bit symbol pattern detector that
//   looks for the sequence 1,2,3. A round-robin arbiter grants one requester
//   per burst. The detector and hit counter are cleared at burst start. The
//   granted requester streams symbols through a valid/ready handshake. One
//   result record is produced per burst.
//
// Optional feature (macro COUNT_ARB_TIMEOUT_EN):
//   When defined, a granted burst that sees TIMEOUT consecutive cycles with no
//   transfer is closed early with res_abort=1. When undefined, a burst waits
//   for sym_last indefinitely and res_abort is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [NREQ]    per-requester burst request (level)
//   sym_in     in   [2*NREQ]  requester i symbol on bits [2i+1:2i]
//   sym_valid  in   [NREQ]    per-requester symbol valid
//   sym_last   in   [NREQ]    per-requester last-symbol marker
//   sym_ready  out  [NREQ]    per-requester symbol accept (granted one, RUN only)
//   gnt        out  [NREQ]    registered one-hot grant
//   res_valid  out            one-cycle result strobe
//   res_id     out  [ID_W]    index of requester just served
//   res_cnt    out  [CNT_W]   saturating hit count of finished burst
//   res_abort  out            burst ended by idle timeout

module count_arbiter #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   sym_in,
    input  logic [NREQ-1:0]     sym_valid,
    input  logic [NREQ-1:0]     sym_last,
    output logic [NREQ-1:0]     sym_ready,
    output logic [NREQ-1:0]     gnt,
    output logic                res_valid,
    output logic [ID_W-1:0]     res_id,
    output logic [CNT_W-1:0]    res_cnt,
    output logic                res_abort
);

    if (NREQ < 2 || NREQ > 8 || ID_W < $clog2(NREQ) || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("count_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_S0 = 2'd0,
        D_S1 = 2'd1,
        D_S2 = 2'd2,
        D_S3 = 2'd3
    } det_t;

    state_t             state;
    state_t             state_nxt;
    det_t               det;
    det_t               det_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic [ID_W-1:0]    cand;

    logic [1:0]         cur_sym;
    logic               cur_valid;
    logic               cur_last;
    logic               xfer;
    logic               hit;
    logic               timeout_hit;
    logic               end_burst;

    // (base + k) mod NREQ, with base always below NREQ and k at most NREQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return ID_W'(s);
    endfunction

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Granted requester's stream; gnt is zero outside a burst so nothing passes.
    always_comb begin
        cur_sym   = 2'd0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                cur_sym   = sym_in[2*i +: 2];
                cur_valid = sym_valid[i];
                cur_last  = sym_last[i];
            end
        end
    end

    assign sym_ready = (state == ST_RUN) ? gnt : '0;
    assign xfer      = (state == ST_RUN) && cur_valid;

    always_comb begin
        det_nxt = det;
        case (det)
            D_S0: det_nxt = (cur_sym == 2'd1) ? D_S1 : D_S0;
            D_S1: begin
                if (cur_sym == 2'd1)      det_nxt = D_S1;
                else if (cur_sym == 2'd2) det_nxt = D_S2;
                else                      det_nxt = D_S0;
            end
            D_S2: begin
                case (cur_sym)
                    2'd0:    det_nxt = D_S0;
                    2'd1:    det_nxt = D_S1;
                    2'd2:    det_nxt = D_S2;
                    default: det_nxt = D_S3;
                endcase
            end
            D_S3: begin
                if (cur_sym == 2'd1)      det_nxt = D_S1;
                else if (cur_sym == 2'd3) det_nxt = D_S3;
                else                      det_nxt = D_S0;
            end
            default: det_nxt = D_S0;
        endcase
    end

    // Only the S2->S3 step is a hit; lingering in S3 on repeated 3s is not.
    assign hit     = xfer && (det == D_S2) && (cur_sym == 2'd3);
    assign cnt_nxt = (hit && (hit_cnt != {CNT_W{1'b1}})) ? hit_cnt + 1'b1 : hit_cnt;

`ifdef COUNT_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              abort_q;

    // The cycle that would bring the idle count to TIMEOUT closes the burst.
    assign timeout_hit = (state == ST_RUN) && !xfer && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                idle_cnt <= '0;
            end else if (state == ST_RUN) begin
                if (xfer) begin
                    idle_cnt <= '0;
                end else if (!timeout_hit) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (end_burst) begin
                    abort_q <= timeout_hit;
                end
            end
        end
    end

    assign res_abort = abort_q;
`else
    assign timeout_hit = 1'b0;
    assign res_abort   = 1'b0;
`endif

    assign end_burst = (state == ST_RUN) && ((xfer && cur_last) || timeout_hit);
    assign res_valid = (state == ST_REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_found) state_nxt = ST_RUN;
            ST_RUN:    if (end_burst)  state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Result fields and rr_ptr are loaded on the edge that enters REPORT, so
    // they are visible for the whole REPORT cycle and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det     <= D_S0;
            rr_ptr  <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            hit_cnt <= '0;
            res_id  <= '0;
            res_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt     <= NREQ'(1) << pick_id;
                        gnt_id  <= pick_id;
                        det     <= D_S0;
                        hit_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        det     <= det_nxt;
                        hit_cnt <= cnt_nxt;
                    end
                    if (end_burst) begin
                        gnt     <= '0;
                        res_id  <= gnt_id;
                        res_cnt <= cnt_nxt;
                        rr_ptr  <= wrap_add(gnt_id, 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - self-checking bench for count_arbiter

module tb_count_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] sym_in;
    logic [3:0] sym_valid;
    logic [3:0] sym_last;
    logic [3:0] sym_ready;
    logic [3:0] gnt;
    logic       res_valid;
    logic [1:0] res_id;
    logic [7:0] res_cnt;
    logic       res_abort;

    logic [3:0] req2;
    logic [7:0] sym_in2;
    logic [3:0] sym_valid2;
    logic [3:0] sym_last2;
    logic [3:0] sym_ready2;
    logic [3:0] gnt2;
    logic       res_valid2;
    logic [1:0] res_id2;
    logic [1:0] res_cnt2;
    logic       res_abort2;

    int checks = 0;
    int errors = 0;
    int rr     = 0;
    logic mon_en = 1'b0;

    int bsym [32];
    int bgap [32];

    typedef struct {
        logic [3:0]  req;
        int          len;
        logic [31:0] syms;
        logic [31:0] gaps;
        int          exp_id;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [10];

    count_arbiter #(.NREQ(4), .CNT_W(8), .ID_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sym_in(sym_in),
        .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready),
        .gnt(gnt), .res_valid(res_valid), .res_id(res_id),
        .res_cnt(res_cnt), .res_abort(res_abort)
    );

    count_arbiter #(.NREQ(4), .CNT_W(2), .ID_W(2), .TIMEOUT(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req2), .sym_in(sym_in2),
        .sym_valid(sym_valid2), .sym_last(sym_last2), .sym_ready(sym_ready2),
        .gnt(gnt2), .res_valid(res_valid2), .res_id(res_id2),
        .res_cnt(res_cnt2), .res_abort(res_abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        end
    end

    // Round-robin reference: first set bit at or after rr, wrapping.
    function automatic int pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    // Hits = number of 3s directly preceded by one or more 2s that follow a 1.
    function automatic int count_hits(input int n);
        int h = 0;
        for (int k = 0; k < n; k++) begin
            if (bsym[k] == 3) begin
                int j = k - 1;
                int twos = 0;
                while (j >= 0 && bsym[j] == 2) begin
                    j--;
                    twos++;
                end
                if (twos > 0 && j >= 0 && bsym[j] == 1) h++;
            end
        end
        return h;
    endfunction

    task automatic drive_noise(input int id);
        sym_in    = 8'($urandom);
        sym_valid = 4'($urandom);
        sym_last  = 4'($urandom);
        sym_valid[id] = 1'b0;
        sym_last[id]  = 1'b0;
    endtask

    // Runs one complete burst from IDLE; returns at the negedge of the IDLE
    // cycle following REPORT with req still applied.
    task automatic do_burst(input string tag, input logic [3:0] r, input int len,
                            input int exp_id, input int exp_cnt);
        int w = 0;
        req = r;
        sym_valid = '0;
        sym_last  = '0;
        @(negedge clk);
        while (gnt == 4'd0 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s gnt", tag), gnt, 32'(4'b0001 << exp_id));
        for (int k = 0; k < len; k++) begin
            for (int g = 0; g < bgap[k]; g++) begin
                drive_noise(exp_id);
                @(negedge clk);
            end
            drive_noise(exp_id);
            sym_valid[exp_id]         = 1'b1;
            sym_in[2*exp_id +: 2]     = 2'(bsym[k]);
            sym_last[exp_id]          = (k == len - 1);
            if (k == 0) chk($sformatf("%s sym_ready", tag), sym_ready, 32'(4'b0001 << exp_id));
            @(negedge clk);
        end
        sym_valid = '0;
        sym_last  = '0;
        chk($sformatf("%s res_valid", tag), res_valid, 1);
        chk($sformatf("%s res_id", tag), res_id, exp_id);
        chk($sformatf("%s res_cnt", tag), res_cnt, exp_cnt);
        chk($sformatf("%s res_abort", tag), res_abort, 0);
        chk($sformatf("%s gnt_report", tag), gnt, 0);
        @(negedge clk);
        chk($sformatf("%s res_valid_drop", tag), res_valid, 0);
        chk($sformatf("%s res_cnt_hold", tag), res_cnt, exp_cnt);
        chk($sformatf("%s gnt_idle", tag), gnt, 0);
        rr = (exp_id + 1) % 4;
    endtask

    initial begin
        int w;
        logic seen;

        tbl[0] = '{4'b0001, 7, 32'h1233123, 32'h0000000, 0, 2};
        tbl[1] = '{4'b0001, 6, 32'h012231,  32'h021010,  0, 1};
        tbl[2] = '{4'b1010, 1, 32'h3,       32'h0,       1, 0};
        tbl[3] = '{4'b1010, 6, 32'h112223,  32'h000000,  3, 1};
        tbl[4] = '{4'b1010, 2, 32'h23,      32'h01,      1, 0};
        tbl[5] = '{4'b1010, 6, 32'h123123,  32'h000200,  3, 2};
        tbl[6] = '{4'b0110, 4, 32'h1232,    32'h0000,    1, 1};
        tbl[7] = '{4'b1111, 3, 32'h333,     32'h000,     2, 0};
        tbl[8] = '{4'b1111, 5, 32'h12123,   32'h00000,   3, 1};
        tbl[9] = '{4'b0011, 4, 32'h1203,    32'h0000,    0, 0};

        rst_n = 1'b0;
        req = '0; sym_in = '0; sym_valid = '0; sym_last = '0;
        req2 = '0; sym_in2 = '0; sym_valid2 = '0; sym_last2 = '0;
        repeat (2) @(negedge clk);
        chk("reset gnt", gnt, 0);
        chk("reset sym_ready", sym_ready, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_id", res_id, 0);
        chk("reset res_cnt", res_cnt, 0);
        chk("reset res_abort", res_abort, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle no req gnt", gnt, 0);
        rr = 0;

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].len; k++) begin
                bsym[k] = int'((tbl[i].syms >> (4 * (tbl[i].len - 1 - k))) & 32'hF);
                bgap[k] = int'((tbl[i].gaps >> (4 * (tbl[i].len - 1 - k))) & 32'hF);
            end
            do_burst($sformatf("vec%0d", i), tbl[i].req, tbl[i].len, tbl[i].exp_id, tbl[i].exp_cnt);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0] r;
            int len;
            int id;
            int h;
            r   = 4'($urandom_range(1, 15));
            len = $urandom_range(1, 12);
            id  = pick(r);
            for (int k = 0; k < len; k++) begin
                bsym[k] = $urandom_range(0, 3);
                bgap[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            h = count_hits(len);
            if (h > 255) h = 255;
            do_burst($sformatf("rnd%0d", i), r, len, id, h);
        end

        // Reset in the middle of a burst on requester 2.
        req = 4'b0100;
        w = 0;
        @(negedge clk);
        while (gnt == 4'd0 && w < 8) begin @(negedge clk); w++; end
        chk("rstmid gnt", gnt, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            sym_valid = 4'b0100;
            sym_in    = 8'(k << 4);
            sym_last  = '0;
            @(negedge clk);
        end
        sym_valid = '0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid gnt_clear", gnt, 0);
        chk("rstmid sym_ready_clear", sym_ready, 0);
        chk("rstmid res_valid_clear", res_valid, 0);
        @(negedge clk);
        chk("rstmid no_report", res_valid, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        rr = 0;
        bsym[0] = 3; bgap[0] = 0;
        do_burst("after_rst", 4'b1111, 1, 0, 0);

        // Idle timeout on requester 2.
        req = 4'b0100;
        w = 0;
        @(negedge clk);
        while (gnt == 4'd0 && w < 8) begin @(negedge clk); w++; end
        chk("tmo gnt", gnt, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            sym_valid = 4'b0100;
            sym_in    = 8'(k << 4);
            sym_last  = '0;
            @(negedge clk);
        end
        sym_valid = '0;
`ifdef COUNT_ARB_TIMEOUT_EN
        w = 0;
        while (!res_valid && w < 20) begin @(negedge clk); w++; end
        chk("tmo idle_cycles", w, 4);
        chk("tmo res_id", res_id, 2);
        chk("tmo res_cnt", res_cnt, 1);
        chk("tmo res_abort", res_abort, 1);
        chk("tmo gnt_drop", gnt, 0);
        @(negedge clk);
        chk("tmo res_valid_drop", res_valid, 0);
`else
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("notmo no_report", seen, 0);
        chk("notmo gnt_held", gnt, 32'h4);
        sym_valid = 4'b0100;
        sym_in    = 8'h30;
        sym_last  = 4'b0100;
        @(negedge clk);
        sym_valid = '0;
        sym_last  = '0;
        chk("notmo res_valid", res_valid, 1);
        chk("notmo res_id", res_id, 2);
        chk("notmo res_cnt", res_cnt, 1);
        chk("notmo res_abort", res_abort, 0);
        @(negedge clk);
`endif
        req = '0;
        rr = 3;
        @(negedge clk);

        // Saturation with a 2-bit counter: five 1,2,3 patterns.
        req2 = 4'b0001;
        w = 0;
        @(negedge clk);
        while (gnt2 == 4'd0 && w < 8) begin @(negedge clk); w++; end
        chk("sat gnt", gnt2, 32'h1);
        for (int k = 0; k < 15; k++) begin
            sym_valid2 = 4'b0001;
            sym_in2    = 8'((k % 3) + 1);
            sym_last2  = (k == 14) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        sym_valid2 = '0;
        sym_last2  = '0;
        req2 = '0;
        chk("sat res_valid", res_valid2, 1);
        chk("sat res_cnt", res_cnt2, 3);
        chk("sat res_id", res_id2, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
